// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline memory stage: FSM state encoding,
// default datapath widths and architectural register indices.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } mem_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_TGT_W  = 27;

  localparam logic [4:0] REG_R0      = 5'd0;
  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_RA      = 5'd31;

endpackage

// File: rtl/dflipflop.sv
// Generic register cell with asynchronous active-low clear, used to build
// pipeline latches.
module dflipflop #(
  parameter int WIDTH = 1
) (
  input  logic             i_clock,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture d on every rising edge; clear drops the contents immediately.
  always_ff @(posedge i_clock or negedge i_clr) begin
    if (!i_clr) r_q <= '0;
    else        r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_ctrl_fsm.sv
// Data-memory handshake controller: tracks the single outstanding request,
// drives dmem_req and generates the memory-stage stall.
module mem_ctrl_fsm
  import pipe_pkg::*;
(
  input  logic i_clock,
  input  logic i_clr,
  input  logic i_mem_op,
  input  logic i_flush,
  input  logic i_ready,
  output logic o_req,
  output logic o_stall,
  output logic o_abort
);

  mem_state_t r_state;
  mem_state_t w_next;
  logic       w_req;
  logic       w_stall;
  logic       w_abort;

  // State register, forced back to IDLE while clear is asserted.
  always_ff @(posedge i_clock or negedge i_clr) begin
    if (!i_clr) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs; a request in flight is never dropped,
  // a flush only turns it into an abort whose data is thrown away.
  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req = i_mem_op;
        if (i_mem_op && !i_ready) begin
          w_next  = ST_WAIT;
          w_stall = 1'b1;
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (i_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_stall = 1'b1;
          if (i_flush) w_next = ST_ABORT;
        end
      end
      ST_ABORT: begin
        w_req   = 1'b1;
        w_abort = 1'b1;
        if (i_ready) w_next  = ST_IDLE;
        else         w_stall = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_req   = w_req & i_clr;
  assign o_stall = w_stall;
  assign o_abort = w_abort;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues lw/sw to data memory, stalls the front of the
// pipeline while an access is outstanding, and loads the M/W latch.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TGT_W  = DEF_TGT_W
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              valid_xm,
  input  logic [DATA_W-1:0] exec_out_xm,
  input  logic [DATA_W-1:0] rd_out1_xm,
  input  logic [4:0]        rd_xm,
  input  logic [TGT_W-1:0]  target_xm,
  input  logic              exception_xm,
  input  logic              isLw_xm,
  input  logic              isSw_xm,
  input  logic              isSetx_xm,
  input  logic              wr_xm,
  input  logic              flush_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall_m,
  output logic [4:0]        fwd_rd_m,
  output logic              fwd_en_m,
  output logic [DATA_W-1:0] fwd_data_m,
  output logic              valid_mw,
  output logic              wb_en_mw,
  output logic [4:0]        rd_mw,
  output logic [DATA_W-1:0] wb_data_mw,
  output logic              exception_mw
);

  localparam int MW_W = DATA_W + 8;

  logic              w_addr_ok;
  logic              w_is_mem;
  logic              w_illegal;
  logic              w_mem_op;
  logic              w_stall;
  logic              w_abort;
  logic              w_bubble;
  logic              w_valid_n;
  logic              w_wben_n;
  logic              w_exc_n;
  logic [DATA_W-1:0] w_setx_val;
  logic [DATA_W-1:0] w_alu_val;
  logic [DATA_W-1:0] w_wb_data;
  logic [MW_W-1:0]   w_mw_d;
  logic [MW_W-1:0]   w_mw_q;

  // Address legality: only the low ADDR_W bits may be non-zero.
  assign w_addr_ok  = ~|exec_out_xm[DATA_W-1:ADDR_W];
  assign w_is_mem   = valid_xm & (isLw_xm | isSw_xm);
  assign w_illegal  = w_is_mem & ~w_addr_ok;
  assign w_mem_op   = w_is_mem & ~exception_xm & ~flush_m & w_addr_ok;

  mem_ctrl_fsm u_ctrl (
    .i_clock (clock),
    .i_clr   (clr),
    .i_mem_op(w_mem_op),
    .i_flush (flush_m),
    .i_ready (dmem_ready),
    .o_req   (dmem_req),
    .o_stall (w_stall),
    .o_abort (w_abort)
  );

  assign stall_m    = w_stall;
  assign dmem_we    = dmem_req & isSw_xm;
  assign dmem_addr  = exec_out_xm[ADDR_W-1:0];
  assign dmem_wdata = rd_out1_xm;

  // Non-load result, shared by the bypass path and writeback selection.
  assign w_setx_val = {{(DATA_W-TGT_W){1'b0}}, target_xm};
  assign w_alu_val  = isSetx_xm ? w_setx_val : exec_out_xm;
  assign w_wb_data  = isLw_xm ? dmem_rdata : w_alu_val;

  // Loads have no value yet in M, so they are never bypassed from here.
  assign fwd_rd_m   = rd_xm;
  assign fwd_en_m   = valid_xm & wr_xm & ~isLw_xm & ~isSw_xm & (rd_xm != REG_R0);
  assign fwd_data_m = w_alu_val;

  // A stalled cycle or the completion of an aborted access inserts a bubble.
  assign w_bubble  = w_stall | w_abort;
  assign w_valid_n = ~w_bubble & valid_xm & ~flush_m;
  assign w_wben_n  = w_valid_n & wr_xm & ~isSw_xm & (rd_xm != REG_R0) & ~w_illegal;
  assign w_exc_n   = ~w_bubble & (exception_xm | w_illegal);

  assign w_mw_d = {w_valid_n, w_wben_n, w_exc_n, rd_xm, w_wb_data};

  dflipflop #(.WIDTH(MW_W)) u_mw_latch (
    .i_clock(clock),
    .i_clr  (clr),
    .i_d    (w_mw_d),
    .o_q    (w_mw_q)
  );

  assign valid_mw     = w_mw_q[MW_W-1];
  assign wb_en_mw     = w_mw_q[MW_W-2];
  assign exception_mw = w_mw_q[MW_W-3];
  assign rd_mw        = w_mw_q[DATA_W+4:DATA_W];
  assign wb_data_mw   = w_mw_q[DATA_W-1:0];

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction model.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        clr;
  logic        valid_xm;
  logic [31:0] exec_out_xm;
  logic [31:0] rd_out1_xm;
  logic [4:0]  rd_xm;
  logic [26:0] target_xm;
  logic        exception_xm;
  logic        isLw_xm;
  logic        isSw_xm;
  logic        isSetx_xm;
  logic        wr_xm;
  logic        flush_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        stall_m;
  logic [4:0]  fwd_rd_m;
  logic        fwd_en_m;
  logic [31:0] fwd_data_m;
  logic        valid_mw;
  logic        wb_en_mw;
  logic [4:0]  rd_mw;
  logic [31:0] wb_data_mw;
  logic        exception_mw;

  int nChecks = 0;
  int nFails  = 0;

  mem_stage dut (
    .clock(clock), .clr(clr), .valid_xm(valid_xm), .exec_out_xm(exec_out_xm),
    .rd_out1_xm(rd_out1_xm), .rd_xm(rd_xm), .target_xm(target_xm),
    .exception_xm(exception_xm), .isLw_xm(isLw_xm), .isSw_xm(isSw_xm),
    .isSetx_xm(isSetx_xm), .wr_xm(wr_xm), .flush_m(flush_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_m(stall_m), .fwd_rd_m(fwd_rd_m), .fwd_en_m(fwd_en_m),
    .fwd_data_m(fwd_data_m), .valid_mw(valid_mw), .wb_en_mw(wb_en_mw),
    .rd_mw(rd_mw), .wb_data_mw(wb_data_mw), .exception_mw(exception_mw)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid, lw, sw, setx, wr, exc, flush;
    logic [31:0] exec, wdata, rdata;
    logic [4:0]  rd;
    logic [26:0] target;
    logic        eReq, eStall, eWe, eValid, eWben, eExc;
    logic [4:0]  eRd;
    logic [31:0] eData;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, lw, sw, setx, wr, exc, flush,
                               input logic [31:0] exec, wdata, input logic [4:0] rd,
                               input logic [26:0] tgt);
    valid_xm = v; isLw_xm = lw; isSw_xm = sw; isSetx_xm = setx; wr_xm = wr;
    exception_xm = exc; flush_m = flush; exec_out_xm = exec; rd_out1_xm = wdata;
    rd_xm = rd; target_xm = tgt;
  endtask

  // Combinational outputs, sampled at the falling edge.
  task automatic checkComb(input string tag, input logic eReq, eStall, eWe);
    logic [31:0] eFwd;
    checkOutput({tag, " dmem_req"}, 32'(dmem_req), 32'(eReq));
    checkOutput({tag, " stall_m"}, 32'(stall_m), 32'(eStall));
    checkOutput({tag, " dmem_we"}, 32'(dmem_we), 32'(eWe));
    if (eReq) begin
      checkOutput({tag, " dmem_addr"}, 32'(dmem_addr), {20'd0, exec_out_xm[11:0]});
      checkOutput({tag, " dmem_wdata"}, dmem_wdata, rd_out1_xm);
    end
    checkOutput({tag, " fwd_rd_m"}, 32'(fwd_rd_m), 32'(rd_xm));
    if (isLw_xm) checkOutput({tag, " fwd_en_m"}, 32'(fwd_en_m), 32'd0);
    else if (valid_xm) begin
      eFwd = isSetx_xm ? {5'd0, target_xm} : exec_out_xm;
      checkOutput({tag, " fwd_data_m"}, fwd_data_m, eFwd);
    end
  endtask

  // M/W latch, sampled 1 time unit after the rising edge.
  task automatic checkMw(input string tag, input logic eValid, eWben, input bit full,
                         input logic [4:0] eRd, input logic [31:0] eData, input logic eExc);
    checkOutput({tag, " valid_mw"}, 32'(valid_mw), 32'(eValid));
    checkOutput({tag, " wb_en_mw"}, 32'(wb_en_mw), 32'(eWben));
    if (full) begin
      checkOutput({tag, " rd_mw"}, 32'(rd_mw), 32'(eRd));
      checkOutput({tag, " exception_mw"}, 32'(exception_mw), 32'(eExc));
      if (eValid) checkOutput({tag, " wb_data_mw"}, wb_data_mw, eData);
    end
  endtask

  task automatic nextEdge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    clr = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 32'h010, 32'h0, 5'd5, 27'd0);
    #2;
    checkOutput("reset dmem_req", 32'(dmem_req), 32'd0);
    checkMw("reset", 0, 0, 1, 5'd0, 32'd0, 0);
    checkOutput("reset wb_data_mw", wb_data_mw, 32'd0);
    valid_xm = 1'b0;
    @(negedge clock);
    clr = 1'b1;
    nextEdge();

    // ---------------- directed vector table ----------------
    vecs[0] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 5'd5, 27'd0,
                1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 5'd5, 32'hDEADBEEF};
    vecs[1] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h1000, 32'h0, 32'hDEADBEEF, 5'd6, 27'd0,
                1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 5'd6, 32'hDEADBEEF};
    vecs[2] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 32'h55, 32'h0, 32'h11111111, 5'd30, 27'h7FF,
                1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 5'd30, 32'h000007FF};
    vecs[3] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h1234, 32'h0, 32'h0, 5'd0, 27'd0,
                1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 5'd0, 32'h1234};
    vecs[4] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'hABCD0000, 32'h0, 32'h0, 5'd7, 27'd0,
                1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 5'd7, 32'hABCD0000};
    vecs[5] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 32'h020, 32'h1234, 32'h0, 5'd9, 27'd0,
                1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 5'd9, 32'h020};
    vecs[6] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 32'h77, 32'h0, 32'h0, 5'd3, 27'd0,
                1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd3, 32'h77};
    vecs[7] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 32'h030, 32'h5, 32'h0, 5'd0, 27'd0,
                1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0, 32'h030};
    vecs[8] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 32'hFFF, 32'h0, 32'hCAFEF00D, 5'd31, 27'd0,
                1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 5'd31, 32'hCAFEF00D};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].lw, vecs[i].sw, vecs[i].setx, vecs[i].wr,
                    vecs[i].exc, vecs[i].flush, vecs[i].exec, vecs[i].wdata,
                    vecs[i].rd, vecs[i].target);
      dmem_ready = 1'b1;
      dmem_rdata = vecs[i].rdata;
      @(negedge clock);
      checkComb($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eStall, vecs[i].eWe);
      nextEdge();
      checkMw($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eWben, 1,
              vecs[i].eRd, vecs[i].eData, vecs[i].eExc);
    end

    // ---------------- sw completing on the third cycle ----------------
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 32'h020, 32'h1234, 5'd9, 27'd0);
    for (int k = 0; k < 3; k++) begin
      dmem_ready = (k == 2);
      @(negedge clock);
      checkComb($sformatf("sw3 c%0d", k), 1, (k < 2), 1);
      nextEdge();
      if (k < 2) checkMw($sformatf("sw3 c%0d", k), 0, 0, 0, 5'd0, 32'd0, 0);
      else       checkMw("sw3 done", 1, 0, 1, 5'd9, 32'h020, 0);
    end

    // ---------------- flush while waiting on a load ----------------
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 32'h040, 32'h0, 5'd4, 27'd0);
    for (int k = 0; k < 4; k++) begin
      flush_m = (k == 1);
      dmem_ready = (k == 3);
      dmem_rdata = 32'h600DF00D;
      @(negedge clock);
      checkComb($sformatf("abort c%0d", k), 1, (k < 3), 0);
      nextEdge();
      checkMw($sformatf("abort c%0d", k), 0, 0, 0, 5'd0, 32'd0, 0);
    end
    // Back in IDLE: a flushed load must not raise a request.
    applyStimulus(1, 1, 0, 0, 1, 0, 1, 32'h044, 32'h0, 5'd4, 27'd0);
    dmem_ready = 1'b0;
    @(negedge clock);
    checkComb("abort idle", 0, 0, 0);
    nextEdge();
    checkMw("abort idle", 0, 0, 1, 5'd4, 32'd0, 0);

    // ---------------- reset while stalled ----------------
    applyStimulus(1, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 5'd30, 27'h7FF);
    @(negedge clock);
    nextEdge();
    checkMw("pre-reset setx", 1, 1, 1, 5'd30, 32'h000007FF, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 32'h050, 32'h0, 5'd5, 27'd0);
    dmem_ready = 1'b0;
    @(negedge clock);
    checkComb("pre-reset lw", 1, 1, 0);
    nextEdge();
    #1;
    clr = 1'b0;
    #1;
    checkOutput("midwait reset dmem_req", 32'(dmem_req), 32'd0);
    checkMw("midwait reset", 0, 0, 1, 5'd0, 32'd0, 0);
    checkOutput("midwait reset wb_data_mw", wb_data_mw, 32'd0);
    valid_xm = 1'b0;
    @(negedge clock);
    clr = 1'b1;
    nextEdge();
    applyStimulus(1, 1, 0, 0, 1, 0, 1, 32'h050, 32'h0, 5'd5, 27'd0);
    @(negedge clock);
    checkComb("post-reset idle", 0, 0, 0);
    nextEdge();

    // ---------------- randomized run against transaction model ----------------
    for (int n = 0; n < 300; n++) begin
      int op, lat, fl;
      logic v, lw, sw, setx, wr, exc, f0, mem, addrOk, killed, flushK, illegal;
      logic eValid, eWben, eExc;
      logic [31:0] exec, eData, rdata;
      logic [4:0] rd;
      logic [26:0] tgt;
      op   = $urandom_range(0, 3);
      lw   = (op == 0); sw = (op == 1); setx = (op == 2);
      v    = ($urandom_range(0, 7) != 0);
      exc  = ($urandom_range(0, 9) == 0);
      wr   = sw ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
      rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      exec = ($urandom_range(0, 5) == 0) ? ($urandom() | 32'h0000_1000) : 32'($urandom_range(0, 4095));
      tgt  = 27'($urandom());
      f0   = ($urandom_range(0, 9) == 0);
      addrOk = (exec < 32'd4096);
      mem  = v & (lw | sw) & ~exc & addrOk & ~f0;
      lat  = $urandom_range(0, 3);
      fl   = (mem && lat >= 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, lat) : 0;
      killed = 1'b0;
      rdata = 32'h0;
      applyStimulus(v, lw, sw, setx, wr, exc, f0, exec, $urandom(), rd, tgt);
      for (int k = 0; k <= (mem ? lat : 0); k++) begin
        flushK = (k == 0) ? f0 : (fl != 0 && k == fl);
        if (k >= 1 && flushK) killed = 1'b1;
        flush_m = flushK;
        dmem_ready = mem ? (k == lat) : 1'($urandom_range(0, 1));
        rdata = $urandom();
        dmem_rdata = rdata;
        @(negedge clock);
        checkComb($sformatf("rnd%0d c%0d", n, k), mem, mem && (k < lat), mem & sw);
        nextEdge();
        if ((mem && k < lat) || killed) begin
          checkMw($sformatf("rnd%0d c%0d", n, k), 0, 0, 0, 5'd0, 32'd0, 0);
        end else begin
          illegal = v & (lw | sw) & ~addrOk;
          eValid  = v & ~flushK;
          eWben   = eValid & wr & ~sw & (rd != 5'd0) & ~illegal;
          eExc    = exc | illegal;
          eData   = lw ? rdata : (setx ? {5'd0, tgt} : exec);
          checkMw($sformatf("rnd%0d", n), eValid, eWben, 1, rd, eData, eExc);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline; consumes the X/M latch outputs, performs lw/sw through a variable-latency data-memory handshake, and produces the registered M/W latch for writeback.
- Generates the pipeline stall while a memory access is outstanding.
- Selects the writeback value from load data, the setx target or the execute result.
- Exports the M-stage bypass value for forwarding.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 12, data-memory word-address width; exec_out_xm bits [DATA_W-1:ADDR_W] must be zero for a legal access
- TGT_W, 27, setx target width

Ports:
- clock  in  1  pipeline clock, rising edge
- clr  in  1  asynchronous, active-low reset
- valid_xm  in  1  X/M holds a live instruction
- exec_out_xm  in  DATA_W  ALU result / effective address
- rd_out1_xm  in  DATA_W  store data
- rd_xm  in  5  destination register
- target_xm  in  TGT_W  setx target
- exception_xm  in  1  upstream exception flag
- isLw_xm, isSw_xm, isSetx_xm  in  1 each  opcode decodes
- wr_xm  in  1  instruction writes a register
- flush_m  in  1  kill the instruction in M (branch/jump redirect)
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable (sw)
- dmem_addr  out  ADDR_W  word address = exec_out_xm[ADDR_W-1:0]
- dmem_wdata  out  DATA_W  = rd_out1_xm
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready=1
- dmem_ready  in  1  request accepted/completed this cycle
- stall_m  out  1  freeze PC, F/D, D/X, X/M this cycle
- fwd_rd_m, fwd_en_m, fwd_data_m  out  5/1/DATA_W  combinational bypass (exec_out_xm or setx value; fwd_en_m=0 for lw)
- valid_mw, wb_en_mw, rd_mw, wb_data_mw, exception_mw  out  1/1/5/DATA_W/1  M/W latch

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE; valid_mw, wb_en_mw, exception_mw=0; rd_mw=0; wb_data_mw=0. dmem_req=0 while clr=0.
- mem_op = valid_xm & (isLw_xm|isSw_xm) & ~exception_xm & ~flush_m & addr_ok. addr_ok = exec_out_xm upper bits all zero.
- Illegal address on lw/sw: no request is issued; exception_mw=1 and wb_en_mw=0 at the next edge.
- FSM states:
  - IDLE: dmem_req=mem_op. If mem_op & dmem_ready, access completes in the same cycle with no stall. If mem_op & ~dmem_ready, go to WAIT with stall_m=1.
  - WAIT: dmem_req=1 with addr/we/wdata held stable (X/M is frozen). stall_m=~dmem_ready. On dmem_ready go to IDLE; the result is latched into M/W at that edge.
  - WAIT + flush_m: the outstanding request cannot be cancelled. Go to ABORT and keep dmem_req=1.
  - ABORT: stall_m=1 until dmem_ready. Data is discarded and M/W gets a bubble. Then return to IDLE.
- M/W load, every edge:
  - stall_m=1: bubble (valid_mw=0, wb_en_mw=0).
  - otherwise: valid_mw = valid_xm & ~flush_m; wb_en_mw = valid_mw & wr_xm & (rd_xm≠0) & ~illegal; rd_mw=rd_xm; exception_mw = exception_xm | illegal.
- wb_data priority: isLw → dmem_rdata; isSetx → zero-extended target_xm; else exec_out_xm.
- Stores never write a register. stall_m is combinational from state, mem_op and dmem_ready.
- A back-to-back lw followed by sw issues the second request in the cycle after completion; there is no dead cycle.
- One outstanding request maximum.

Decomposition:
- Shared package pipe_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, ABORT=2'd2), DATA_W/ADDR_W/TGT_W defaults, register index constants (r0=0, rstatus=30, ra=31).
- One sub-module, mem_ctrl_fsm, owns state, dmem_req and stall_m. The M/W latch is built from the existing dflipflop cells with asynchronous clear.

Test Plan:
- Zero-wait lw: valid, isLw, exec_out=0x010, rd=5, memory returns 0xDEADBEEF with ready same cycle → stall_m never 1; next edge valid_mw=1, wb_en_mw=1, rd_mw=5, wb_data_mw=0xDEADBEEF.
- 3-cycle sw: exec_out=0x020, rd_out1=0x1234, ready after 3 cycles → stall_m=1 for 2 cycles; dmem_we=1 and addr/wdata stable throughout; M/W bubbles for 2 cycles, then valid_mw=1, wb_en_mw=0.
- Flush during WAIT: lw pending, flush_m=1 in WAIT, ready 2 cycles later → state ABORT; dmem_req stays 1 until ready; no M/W write; IDLE afterwards.
- Illegal address: lw exec_out=0x0000_1000 → dmem_req=0, stall_m=0, exception_mw=1, wb_en_mw=0.
- Setx / r0: setx target=0x7FF → wb_data_mw=0x000007FF, rd_mw=30; add with rd=0 → wb_en_mw=0.
- Reset mid-WAIT: clr=0 while stalled → all M/W outputs 0, dmem_req=0 immediately, state IDLE after release.
